// File: rtl/state_sequencer.sv
// Multicycle instruction state sequencer.
// Steps each instruction through IF, ID, EX, MEM, WB and PCPL according to its
// opcode, stalls on the memory handshake, aborts on memory wait timeout, and
// reports write strobes, retire pulses, sticky error flags and a retire count.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   power       run enable; low freezes every register
//   OP          opcode field from the instruction register
//   mem_ready   memory access completes this cycle
//   state       current state: IF=0 ID=1 EX=2 MEM=3 WB=4 PCPL=5
//   ir_write    load instruction register (IF & mem_ready & power)
//   pc_write    update PC (PCPL & power)
//   instr_done  registered one-cycle pulse when an instruction retires
//   illegal_op  sticky: unrecognised opcode decoded
//   mem_timeout sticky: memory wait exceeded WAIT_MAX
//   retired     saturating count of retired instructions
module state_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             power,
  input  logic [5:0]       OP,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_write,
  output logic             pc_write,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [5:0] OpRformat = 6'h00;
  localparam logic [5:0] OpJump    = 6'h02;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpLdrw    = 6'h23;
  localparam logic [5:0] OpStrw    = 6'h2B;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StPcpl = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic op_legal;
  logic wait_expired;

  always_comb begin
    unique case (OP)
      OpRformat, OpAddi, OpAddiu, OpLdrw, OpStrw,
      OpBeq, OpBne, OpBlez, OpJump: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  end

  assign wait_expired = (wait_q == WaitW'(WAIT_MAX));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retired_d = retired_q;

    if (power) begin
      case (state_q)
        StIf: begin
          // mem_ready wins over an expiring wait on the same cycle
          if (mem_ready) begin
            state_d = StId;
          end else if (wait_expired) begin
            state_d   = StPcpl;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StId: begin
          op_d = OP;
          if (op_legal) begin
            state_d = StEx;
          end else begin
            state_d   = StPcpl;
            illegal_d = 1'b1;
          end
        end
        StEx: begin
          unique case (op_q)
            OpLdrw, OpStrw:             state_d = StMem;
            OpRformat, OpAddi, OpAddiu: state_d = StWb;
            default:                    state_d = StPcpl;
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            state_d = (op_q == OpLdrw) ? StWb : StPcpl;
          end else if (wait_expired) begin
            // abandoned access still retires through PCPL
            state_d   = StPcpl;
            timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        StWb: state_d = StPcpl;
        StPcpl: begin
          state_d = StIf;
          done_d  = 1'b1;
          if (retired_q != '1) begin
            retired_d = retired_q + 1'b1;
          end
        end
        default: state_d = StIf;
      endcase

      if (state_d != state_q) begin
        wait_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIf;
      op_q      <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  assign state       = state_q;
  assign ir_write    = (state_q == StIf) & mem_ready & power;
  assign pc_write    = (state_q == StPcpl) & power;
  assign instr_done  = done_q & power;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign retired     = retired_q;

endmodule
